// File: rtl/fir_interp2_mac.sv
// fir_interp2_mac: sequential 2x polyphase interpolating FIR.
// Each accepted 8-bit signed sample produces two 16-bit signed outputs.
// The even phase comes first, then the odd phase. One shared multiplier
// and an 18-bit accumulator are stepped through one tap per clock.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high
//   in_valid  input sample valid
//   in_data   signed 8-bit input sample
//   in_ready  block can accept a sample (IDLE only)
//   out_valid out_data/out_phase valid
//   out_data  signed 16-bit interpolated sample
//   out_ready downstream accepts out_data
//   out_phase 0 = even sample, 1 = odd sample
//   busy      FSM not in IDLE
module fir_interp2_mac #(
  parameter logic signed [7:0] COEFF0 = -8'sd9,
  parameter logic signed [7:0] COEFF1 = -8'sd3,
  parameter logic signed [7:0] COEFF2 = 8'sd12,
  parameter logic signed [7:0] COEFF3 = 8'sd26,
  parameter logic signed [7:0] COEFF4 = 8'sd26,
  parameter logic signed [7:0] COEFF5 = 8'sd12,
  parameter logic signed [7:0] COEFF6 = -8'sd3,
  parameter logic signed [7:0] COEFF7 = -8'sd9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        out_phase,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    MAC_E,
    OUT_E,
    MAC_O,
    OUT_O
  } state_t;

  state_t state, state_next;

  logic signed [7:0]  x [4];
  logic signed [17:0] acc;
  logic [1:0]         tap;
  logic signed [7:0]  coeff_sel;
  logic signed [7:0]  x_sel;
  logic signed [15:0] prod;
  logic signed [17:0] sum;
  logic               accept;
  logic               odd_phase;

  assign accept    = in_valid && (state == IDLE);
  assign odd_phase = (state == MAC_O);

  // Polyphase split: even phase uses the even-numbered taps and odd phase
  // uses the odd-numbered taps. The tap index selects both the coefficient
  // and the delay-line element.
  always_comb begin
    coeff_sel = '0;
    unique case ({odd_phase, tap})
      3'b000: coeff_sel = COEFF0;
      3'b001: coeff_sel = COEFF2;
      3'b010: coeff_sel = COEFF4;
      3'b011: coeff_sel = COEFF6;
      3'b100: coeff_sel = COEFF1;
      3'b101: coeff_sel = COEFF3;
      3'b110: coeff_sel = COEFF5;
      3'b111: coeff_sel = COEFF7;
    endcase
    x_sel = x[tap];
    prod  = 16'(coeff_sel) * 16'(x_sel);
    sum   = acc + 18'(prod);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC_E;
      end
      MAC_E: if (tap == 2'd3) state_next = OUT_E;
      OUT_E: begin
        out_valid = 1'b1;
        if (out_ready) state_next = MAC_O;
      end
      MAC_O: if (tap == 2'd3) state_next = OUT_O;
      OUT_O: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) x[i] <= '0;
      acc       <= '0;
      tap       <= '0;
      out_data  <= '0;
      out_phase <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            x[0] <= $signed(in_data);
            for (int unsigned i = 1; i < 4; i++) x[i] <= x[i-1];
            acc <= '0;
            tap <= '0;
          end
        end
        MAC_E, MAC_O: begin
          acc <= sum;
          tap <= tap + 2'd1;
          if (tap == 2'd3) begin
            // The coefficient set bounds |sum| well inside 16 bits.
            // Bits 17:15 must therefore all equal the sign.
            assert (sum[17:15] == 3'b000 || sum[17:15] == 3'b111);
            out_data  <= sum[15:0];
            out_phase <= odd_phase;
          end
        end
        OUT_E: begin
          if (out_ready) begin
            acc <= '0;
            tap <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
